// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Purpose:
//   Shares one external memory port between the instruction-fetch requester
//   (read-only) and the data-memory requester (read/write). Only one
//   transaction is outstanding at a time. When both requesters are valid,
//   arbitration is round-robin. The arbiter also provides the in-flight
//   indications that the pipeline hazard unit uses for stall generation.
//
// Optional feature:
//   `define RVGA_MEM_TIMEOUT_EN enables a response watchdog. If no response
//   arrives within TIMEOUT_CYCLES cycles of RESP, the owner receives an error
//   response (data 0, err_o = 1).
//
// Ports:
//   clk_i, rst_i                   clock, synchronous active-low reset
//   imem_req_v_i/addr_i            fetch request
//   imem_req_ready_o               fetch request accepted (comb, IDLE only)
//   imem_resp_v_o/data_o           fetch response pulse and data
//   dmem_req_v_i/we_i/addr_i/
//     wdata_i/wmask_i              data request
//   dmem_req_ready_o               data request accepted (comb, IDLE only)
//   dmem_resp_v_o/rdata_o          data response / write ack pulse and data
//   imem_read_v_o, dmem_read_v_o   transaction in flight per requester
//   err_o                          qualifies a response pulse as a timeout
//   mem_req_v_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o
//                                  registered request to memory
//   mem_req_ready_i                memory accepts the request
//   mem_resp_v_i, mem_rdata_i      memory response
// -----------------------------------------------------------------------------
module mem_arbiter #(
   parameter int AW             = 32,
   parameter int DW             = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            imem_req_v_i,
   input  logic [AW-1:0]   imem_addr_i,
   output logic            imem_req_ready_o,
   output logic            imem_resp_v_o,
   output logic [DW-1:0]   imem_data_o,
   input  logic            dmem_req_v_i,
   input  logic            dmem_we_i,
   input  logic [AW-1:0]   dmem_addr_i,
   input  logic [DW-1:0]   dmem_wdata_i,
   input  logic [DW/8-1:0] dmem_wmask_i,
   output logic            dmem_req_ready_o,
   output logic            dmem_resp_v_o,
   output logic [DW-1:0]   dmem_rdata_o,
   output logic            imem_read_v_o,
   output logic            dmem_read_v_o,
   output logic            err_o,
   output logic            mem_req_v_o,
   output logic            mem_we_o,
   output logic [AW-1:0]   mem_addr_o,
   output logic [DW-1:0]   mem_wdata_o,
   output logic [DW/8-1:0] mem_wmask_o,
   input  logic            mem_req_ready_i,
   input  logic            mem_resp_v_i,
   input  logic [DW-1:0]   mem_rdata_i
);

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

   state_t            state_q, state_d;
   logic              owner_q, owner_d;         // 1 = dmem owns the transaction
   logic              rr_imem_q, rr_imem_d;     // 1 = imem wins the next tie
   logic              mem_we_q, mem_we_d;
   logic [AW-1:0]     mem_addr_q, mem_addr_d;
   logic [DW-1:0]     mem_wdata_q, mem_wdata_d;
   logic [DW/8-1:0]   mem_wmask_q, mem_wmask_d;
   logic              imem_resp_v_q, imem_resp_v_d;
   logic              dmem_resp_v_q, dmem_resp_v_d;
   logic [DW-1:0]     imem_data_q, imem_data_d;
   logic [DW-1:0]     dmem_rdata_q, dmem_rdata_d;
   logic              imem_read_v_q, imem_read_v_d;
   logic              dmem_read_v_q, dmem_read_v_d;
   logic              err_q, err_d;
   logic              gnt_imem, gnt_dmem;
   logic              timeout_hit;

`ifdef RVGA_MEM_TIMEOUT_EN
   localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);
   logic [15:0] tmo_cnt_q, tmo_cnt_d;
   assign timeout_hit = (tmo_cnt_q >= TMO_LIMIT);
`else
   // Watchdog absent: RESP waits indefinitely. The comparison only keeps the
   // parameter referenced in this build and folds to constant 0.
   assign timeout_hit = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      rr_imem_d     = rr_imem_q;
      mem_we_d      = mem_we_q;
      mem_addr_d    = mem_addr_q;
      mem_wdata_d   = mem_wdata_q;
      mem_wmask_d   = mem_wmask_q;
      imem_resp_v_d = 1'b0;
      dmem_resp_v_d = 1'b0;
      imem_data_d   = imem_data_q;
      dmem_rdata_d  = dmem_rdata_q;
      imem_read_v_d = imem_read_v_q;
      dmem_read_v_d = dmem_read_v_q;
      err_d         = 1'b0;
      gnt_imem      = 1'b0;
      gnt_dmem      = 1'b0;
`ifdef RVGA_MEM_TIMEOUT_EN
      tmo_cnt_d     = tmo_cnt_q;
`endif
      case (state_q)
         IDLE: begin
            gnt_dmem = dmem_req_v_i & (~imem_req_v_i | ~rr_imem_q);
            gnt_imem = imem_req_v_i & (~dmem_req_v_i |  rr_imem_q);
            // In-flight flags cover the response cycle, so they only drop
            // one cycle after returning to IDLE (unless a new grant follows).
            imem_read_v_d = 1'b0;
            dmem_read_v_d = 1'b0;
            if (gnt_dmem) begin
               owner_d       = 1'b1;
               rr_imem_d     = 1'b1;
               mem_we_d      = dmem_we_i;
               mem_addr_d    = dmem_addr_i;
               mem_wdata_d   = dmem_wdata_i;
               mem_wmask_d   = dmem_wmask_i;
               dmem_read_v_d = 1'b1;
               state_d       = REQ;
            end else if (gnt_imem) begin
               owner_d       = 1'b0;
               rr_imem_d     = 1'b0;
               mem_we_d      = 1'b0;
               mem_addr_d    = imem_addr_i;
               mem_wdata_d   = '0;
               mem_wmask_d   = '0;
               imem_read_v_d = 1'b1;
               state_d       = REQ;
            end
         end
         REQ: begin
            if (mem_req_ready_i) begin
               state_d = RESP;
`ifdef RVGA_MEM_TIMEOUT_EN
               tmo_cnt_d = '0;
`endif
            end
         end
         RESP: begin
`ifdef RVGA_MEM_TIMEOUT_EN
            tmo_cnt_d = tmo_cnt_q + 16'd1;
`endif
            // A real response takes priority over a coincident expiry.
            if (mem_resp_v_i) begin
               state_d = IDLE;
               if (owner_q) begin
                  dmem_resp_v_d = 1'b1;
                  dmem_rdata_d  = mem_we_q ? '0 : mem_rdata_i;
               end else begin
                  imem_resp_v_d = 1'b1;
                  imem_data_d   = mem_rdata_i;
               end
            end else if (timeout_hit) begin
               state_d = IDLE;
               err_d   = 1'b1;
               if (owner_q) begin
                  dmem_resp_v_d = 1'b1;
                  dmem_rdata_d  = '0;
               end else begin
                  imem_resp_v_d = 1'b1;
                  imem_data_d   = '0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q       <= IDLE;
         owner_q       <= 1'b0;
         rr_imem_q     <= 1'b0;
         mem_we_q      <= 1'b0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
         mem_wmask_q   <= '0;
         imem_resp_v_q <= 1'b0;
         dmem_resp_v_q <= 1'b0;
         imem_data_q   <= '0;
         dmem_rdata_q  <= '0;
         imem_read_v_q <= 1'b0;
         dmem_read_v_q <= 1'b0;
         err_q         <= 1'b0;
`ifdef RVGA_MEM_TIMEOUT_EN
         tmo_cnt_q     <= '0;
`endif
      end else begin
         state_q       <= state_d;
         owner_q       <= owner_d;
         rr_imem_q     <= rr_imem_d;
         mem_we_q      <= mem_we_d;
         mem_addr_q    <= mem_addr_d;
         mem_wdata_q   <= mem_wdata_d;
         mem_wmask_q   <= mem_wmask_d;
         imem_resp_v_q <= imem_resp_v_d;
         dmem_resp_v_q <= dmem_resp_v_d;
         imem_data_q   <= imem_data_d;
         dmem_rdata_q  <= dmem_rdata_d;
         imem_read_v_q <= imem_read_v_d;
         dmem_read_v_q <= dmem_read_v_d;
         err_q         <= err_d;
`ifdef RVGA_MEM_TIMEOUT_EN
         tmo_cnt_q     <= tmo_cnt_d;
`endif
      end
   end

   assign imem_req_ready_o = gnt_imem;
   assign dmem_req_ready_o = gnt_dmem;
   assign imem_resp_v_o    = imem_resp_v_q;
   assign imem_data_o      = imem_data_q;
   assign dmem_resp_v_o    = dmem_resp_v_q;
   assign dmem_rdata_o     = dmem_rdata_q;
   assign imem_read_v_o    = imem_read_v_q;
   assign dmem_read_v_o    = dmem_read_v_q;
   assign err_o            = err_q;
   assign mem_req_v_o      = (state_q == REQ);
   assign mem_we_o         = mem_we_q;
   assign mem_addr_o       = mem_addr_q;
   assign mem_wdata_o      = mem_wdata_q;
   assign mem_wmask_o      = mem_wmask_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter. Expected responses are pushed to a queue
// when a request is issued and popped whenever the DUT pulses a response.
// Define RVGA_MEM_TIMEOUT_EN to build the watchdog variant (TIMEOUT_CYCLES=8).
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_i = 1'b0;
   logic        imem_req_v_i = 1'b0;
   logic [31:0] imem_addr_i = '0;
   logic        imem_req_ready_o, imem_resp_v_o;
   logic [31:0] imem_data_o;
   logic        dmem_req_v_i = 1'b0, dmem_we_i = 1'b0;
   logic [31:0] dmem_addr_i = '0, dmem_wdata_i = '0;
   logic [3:0]  dmem_wmask_i = '0;
   logic        dmem_req_ready_o, dmem_resp_v_o;
   logic [31:0] dmem_rdata_o;
   logic        imem_read_v_o, dmem_read_v_o, err_o;
   logic        mem_req_v_o, mem_we_o;
   logic [31:0] mem_addr_o, mem_wdata_o;
   logic [3:0]  mem_wmask_o;
   logic        mem_req_ready_i = 1'b0, mem_resp_v_i = 1'b0;
   logic [31:0] mem_rdata_i = '0;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        is_d;
      logic [31:0] data;
      logic        err;
   } exp_t;
   exp_t exp_q[$];

   always #5 clk = ~clk;

`ifdef RVGA_MEM_TIMEOUT_EN
   localparam int TMO = 8;
`else
   localparam int TMO = 256;
`endif

   mem_arbiter #(.AW(32), .DW(32), .TIMEOUT_CYCLES(TMO)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .imem_req_v_i(imem_req_v_i), .imem_addr_i(imem_addr_i),
      .imem_req_ready_o(imem_req_ready_o), .imem_resp_v_o(imem_resp_v_o),
      .imem_data_o(imem_data_o),
      .dmem_req_v_i(dmem_req_v_i), .dmem_we_i(dmem_we_i),
      .dmem_addr_i(dmem_addr_i), .dmem_wdata_i(dmem_wdata_i),
      .dmem_wmask_i(dmem_wmask_i), .dmem_req_ready_o(dmem_req_ready_o),
      .dmem_resp_v_o(dmem_resp_v_o), .dmem_rdata_o(dmem_rdata_o),
      .imem_read_v_o(imem_read_v_o), .dmem_read_v_o(dmem_read_v_o),
      .err_o(err_o),
      .mem_req_v_o(mem_req_v_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o),
      .mem_req_ready_i(mem_req_ready_i), .mem_resp_v_i(mem_resp_v_i),
      .mem_rdata_i(mem_rdata_i)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one clock; sample 1 time unit after the edge and retire any
   // response pulse against the scoreboard.
   task automatic cyc();
      exp_t e;
      @(posedge clk);
      #1;
      if (imem_resp_v_o === 1'b1 || dmem_resp_v_o === 1'b1) begin
         chk("single_resp", {31'd0, imem_resp_v_o & dmem_resp_v_o}, 0);
         if (exp_q.size() == 0) begin
            chk("unexpected_resp", 1, 0);
         end else begin
            e = exp_q.pop_front();
            chk("resp_owner_dmem", {31'd0, dmem_resp_v_o}, {31'd0, e.is_d});
            chk("resp_data", e.is_d ? dmem_rdata_o : imem_data_o, e.data);
            chk("resp_err", {31'd0, err_o}, {31'd0, e.err});
            $display("resp: owner=%s data=%h err=%0d",
                     e.is_d ? "dmem" : "imem", e.is_d ? dmem_rdata_o : imem_data_o, err_o);
         end
      end
   endtask

   task automatic push(input logic is_d, input logic [31:0] data, input logic err);
      exp_t e;
      e.is_d = is_d;
      e.data = data;
      e.err  = err;
      exp_q.push_back(e);
   endtask

   // Memory side: wait for a request, hold it 'stall' cycles while checking
   // the fields stay stable, accept, then respond the following cycle.
   task automatic serve(input int stall, input logic [31:0] rdata, input logic ewe,
                        input logic [31:0] eaddr, input logic [31:0] ewdata,
                        input logic [3:0] emask);
      int n = 0;
      while (mem_req_v_o !== 1'b1 && n < 20) begin
         cyc();
         n++;
      end
      chk("req_wait", {31'd0, mem_req_v_o}, 1);
      for (int i = 0; i <= stall; i++) begin
         chk("req_v_hold", {31'd0, mem_req_v_o}, 1);
         chk("req_we", {31'd0, mem_we_o}, {31'd0, ewe});
         chk("req_addr", mem_addr_o, eaddr);
         chk("req_wdata", mem_wdata_o, ewdata);
         chk("req_wmask", {28'd0, mem_wmask_o}, {28'd0, emask});
         if (i == stall) mem_req_ready_i = 1'b1;
         cyc();
      end
      mem_req_ready_i = 1'b0;
      $display("mem: addr=%h we=%0d accepted after %0d stall cycles", eaddr, ewe, stall);
      mem_resp_v_i = 1'b1;
      mem_rdata_i  = rdata;
      cyc();
      mem_resp_v_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "simulation time limit");
   end

   initial begin
      // ---------------- reset state ----------------
      repeat (3) cyc();
      chk("rst_mem_req_v", {31'd0, mem_req_v_o}, 0);
      chk("rst_mem_addr", mem_addr_o, 0);
      chk("rst_imem_read_v", {31'd0, imem_read_v_o}, 0);
      chk("rst_dmem_read_v", {31'd0, dmem_read_v_o}, 0);
      chk("rst_err", {31'd0, err_o}, 0);
      chk("rst_imem_data", imem_data_o, 0);
      rst_i = 1'b1;
      cyc();

      // ---------------- single imem read, latency ----------------
      imem_req_v_i = 1'b1;
      imem_addr_i  = 32'h100;
      #1;
      chk("t1_ready", {31'd0, imem_req_ready_o}, 1);
      push(1'b0, 32'hDEADBEEF, 1'b0);
      cyc();                                   // T+1
      imem_req_v_i = 1'b0;
      chk("t1_req_v", {31'd0, mem_req_v_o}, 1);
      chk("t1_addr", mem_addr_o, 32'h100);
      chk("t1_read_v_t1", {31'd0, imem_read_v_o}, 1);
      mem_req_ready_i = 1'b1;
      cyc();                                   // T+2
      mem_req_ready_i = 1'b0;
      chk("t1_req_v_drop", {31'd0, mem_req_v_o}, 0);
      chk("t1_read_v_t2", {31'd0, imem_read_v_o}, 1);
      chk("t1_no_early_resp", {31'd0, imem_resp_v_o}, 0);
      mem_resp_v_i = 1'b1;
      mem_rdata_i  = 32'hDEADBEEF;
      cyc();                                   // T+3
      mem_resp_v_i = 1'b0;
      chk("t1_resp_t3", {31'd0, imem_resp_v_o}, 1);
      chk("t1_read_v_t3", {31'd0, imem_read_v_o}, 1);
      cyc();                                   // T+4
      chk("t1_read_v_t4", {31'd0, imem_read_v_o}, 0);
      chk("t1_resp_pulse", {31'd0, imem_resp_v_o}, 0);
      chk("t1_data_hold", imem_data_o, 32'hDEADBEEF);

      // ---------------- round robin, both held ----------------
      // Fresh reset so the pointer favours dmem again.
      rst_i = 1'b0;
      cyc();
      rst_i = 1'b1;
      imem_req_v_i = 1'b1;
      imem_addr_i  = 32'h104;
      dmem_req_v_i = 1'b1;
      dmem_we_i    = 1'b0;
      dmem_addr_i  = 32'h40;
      dmem_wdata_i = 32'h0;
      dmem_wmask_i = 4'h0;
      #1;
      chk("rr_first_dmem", {31'd0, dmem_req_ready_o}, 1);
      chk("rr_first_imem_lose", {31'd0, imem_req_ready_o}, 0);
      push(1'b1, 32'hA0A0A0A0, 1'b0);
      push(1'b0, 32'hB1B1B1B1, 1'b0);
      push(1'b1, 32'hC2C2C2C2, 1'b0);
      push(1'b0, 32'hD3D3D3D3, 1'b0);
      serve(0, 32'hA0A0A0A0, 1'b0, 32'h40,  32'h0, 4'h0);
      serve(0, 32'hB1B1B1B1, 1'b0, 32'h104, 32'h0, 4'h0);
      serve(0, 32'hC2C2C2C2, 1'b0, 32'h40,  32'h0, 4'h0);
      serve(0, 32'hD3D3D3D3, 1'b0, 32'h104, 32'h0, 4'h0);
      imem_req_v_i = 1'b0;
      dmem_req_v_i = 1'b0;
      cyc();
      chk("rr_queue_drained", exp_q.size(), 0);

      // ---------------- dmem write with request stall ----------------
      dmem_req_v_i = 1'b1;
      dmem_we_i    = 1'b1;
      dmem_addr_i  = 32'h20;
      dmem_wdata_i = 32'h12345678;
      dmem_wmask_i = 4'hF;
      push(1'b1, 32'h0, 1'b0);
      cyc();
      dmem_req_v_i = 1'b0;
      dmem_we_i    = 1'b0;
      chk("wr_read_v", {31'd0, dmem_read_v_o}, 1);
      serve(3, 32'hCAFEF00D, 1'b1, 32'h20, 32'h12345678, 4'hF);
      chk("wr_ack", {31'd0, dmem_resp_v_o}, 1);
      chk("wr_rdata_zero", dmem_rdata_o, 0);

      // ---------------- reset during RESP ----------------
      cyc();
      imem_req_v_i = 1'b1;
      imem_addr_i  = 32'h200;
      cyc();
      imem_req_v_i = 1'b0;
      mem_req_ready_i = 1'b1;
      cyc();                                   // now in RESP
      mem_req_ready_i = 1'b0;
      rst_i = 1'b0;
      cyc();
      rst_i = 1'b1;
      mem_resp_v_i = 1'b1;
      mem_rdata_i  = 32'h99999999;
      cyc();
      mem_resp_v_i = 1'b0;
      cyc();
      chk("rst_mid_no_resp", {31'd0, imem_resp_v_o}, 0);
      chk("rst_mid_read_v", {31'd0, imem_read_v_o}, 0);
      chk("rst_mid_req_v", {31'd0, mem_req_v_o}, 0);
      chk("rst_mid_addr", mem_addr_o, 0);
      chk("rst_mid_data", imem_data_o, 0);
      imem_req_v_i = 1'b1;
      imem_addr_i  = 32'h208;
      push(1'b0, 32'h55AA55AA, 1'b0);
      cyc();
      imem_req_v_i = 1'b0;
      serve(0, 32'h55AA55AA, 1'b0, 32'h208, 32'h0, 4'h0);
      chk("rst_mid_recover", {31'd0, imem_resp_v_o}, 1);

      // ---------------- response cycle coincides with new dmem request ----
      cyc();
      imem_req_v_i = 1'b1;
      imem_addr_i  = 32'h300;
      push(1'b0, 32'h01020304, 1'b0);
      cyc();
      imem_req_v_i = 1'b0;
      serve(0, 32'h01020304, 1'b0, 32'h300, 32'h0, 4'h0);
      dmem_req_v_i = 1'b1;
      dmem_we_i    = 1'b0;
      dmem_addr_i  = 32'h44;
      dmem_wdata_i = 32'h0;
      dmem_wmask_i = 4'h0;
      #1;
      chk("b2b_resp_now", {31'd0, imem_resp_v_o}, 1);
      chk("b2b_ready", {31'd0, dmem_req_ready_o}, 1);
      push(1'b1, 32'h0BADF00D, 1'b0);
      cyc();
      dmem_req_v_i = 1'b0;
      chk("b2b_req_v", {31'd0, mem_req_v_o}, 1);
      chk("b2b_addr", mem_addr_o, 32'h44);
      serve(0, 32'h0BADF00D, 1'b0, 32'h44, 32'h0, 4'h0);

      // ---------------- missing response ----------------
      cyc();
      imem_req_v_i = 1'b1;
      imem_addr_i  = 32'h400;
      cyc();
      imem_req_v_i = 1'b0;
      mem_req_ready_i = 1'b1;
      cyc();                                   // first RESP cycle
      mem_req_ready_i = 1'b0;
`ifdef RVGA_MEM_TIMEOUT_EN
      push(1'b0, 32'h0, 1'b1);
      for (int k = 1; k <= 9; k++) begin
         cyc();
         chk("tmo_resp_timing", {31'd0, imem_resp_v_o}, (k == 9) ? 1 : 0);
      end
      chk("tmo_err", {31'd0, err_o}, 1);
      chk("tmo_data", imem_data_o, 0);
      cyc();
      chk("tmo_err_pulse", {31'd0, err_o}, 0);
`else
      for (int k = 1; k <= 20; k++) begin
         cyc();
         chk("no_tmo_resp", {31'd0, imem_resp_v_o}, 0);
      end
      chk("no_tmo_err", {31'd0, err_o}, 0);
      chk("no_tmo_read_v", {31'd0, imem_read_v_o}, 1);
`endif
      rst_i = 1'b0;
      cyc();
      rst_i = 1'b1;
      cyc();

      chk("queue_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
